dunit_prog_loader: RTL and testbench



---
 rtl/dunit_prog_loader.sv | 177 +++++++++++++++++
 tb/tb_dunit_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dunit_prog_loader.sv
// Debug-unit program loader: assembles serial bytes into instruction words, writes them
// to instruction memory, and drives the pipeline clock-enable for run and single-step.
module dunit_prog_loader #(
   parameter int                 NB_REG   = 32,
   parameter int                 NB_BYTE  = 8,
   parameter int                 NB_WIDHT = 9,
   parameter logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C,
   parameter logic [NB_BYTE-1:0] CMD_CONT = 8'h43,
   parameter logic [NB_BYTE-1:0] CMD_STEP = 8'h53,
   parameter logic [NB_BYTE-1:0] CMD_RST  = 8'h52
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NB_BYTE-1:0]  i_rx_data,
   input  logic                i_rx_valid,
   input  logic                i_halt,
   output logic                o_dunit_w_mem,
   output logic [NB_WIDHT-1:0] o_dunit_addr,
   output logic [NB_REG-1:0]   o_dunit_data_if,
   output logic                o_dunit_clk_en,
   output logic                o_dunit_reset_pc,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
);
   localparam int BPW = NB_REG / NB_BYTE;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [NB_WIDHT+1:0] STRIDE = (NB_WIDHT+2)'(NB_REG / 8);
   localparam logic [NB_WIDHT+1:0] LIMIT  = (NB_WIDHT+2)'(1) << NB_WIDHT;

   typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_DATA, WRITE, RUN, STEP} state_t;

   state_t              state_q, state_d;
   // One extra bit so an address equal to the memory size is representable.
   logic [NB_WIDHT:0]   addr_q, addr_d;
   logic [NB_BYTE-1:0]  nwords_q, nwords_d;
   logic [CW-1:0]       bcnt_q, bcnt_d;
   logic [NB_REG-1:0]   word_q, word_d, dout_q, dout_d;
   logic [NB_WIDHT-1:0] aout_q, aout_d;
   logic                ovf_q, ovf_d;
   logic                wmem_q, wmem_d, rstpc_q, rstpc_d, done_q, done_d, err_q, err_d;
   logic [NB_WIDHT+1:0] addr_nx_q, addr_nx_d;
   logic                take_byte;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         nwords_q <= '0;
         bcnt_q   <= '0;
         word_q   <= '0;
         dout_q   <= '0;
         aout_q   <= '0;
         ovf_q    <= 1'b0;
         wmem_q   <= 1'b0;
         rstpc_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         nwords_q <= nwords_d;
         bcnt_q   <= bcnt_d;
         word_q   <= word_d;
         dout_q   <= dout_d;
         aout_q   <= aout_d;
         ovf_q    <= ovf_d;
         wmem_q   <= wmem_d;
         rstpc_q  <= rstpc_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      nwords_d  = nwords_q;
      bcnt_d    = bcnt_q;
      word_d    = word_q;
      dout_d    = dout_q;
      aout_d    = aout_q;
      ovf_d     = ovf_q;
      wmem_d    = 1'b0;
      rstpc_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      take_byte = 1'b0;
      addr_nx_q = {1'b0, addr_q} + STRIDE;

      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     state_d = LOAD_CNT;
                     addr_d  = '0;
                     ovf_d   = 1'b0;
                     bcnt_d  = '0;
                  end
                  CMD_CONT: state_d = RUN;
                  CMD_STEP: state_d = STEP;
                  CMD_RST: begin
                     rstpc_d = 1'b1;
                     done_d  = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         LOAD_CNT: begin
            if (i_rx_valid) begin
               if (i_rx_data == '0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  nwords_d = i_rx_data;
                  state_d  = LOAD_DATA;
               end
            end
         end
         LOAD_DATA: take_byte = i_rx_valid;
         WRITE: begin
            // Address saturates once past the top, so every later word is also dropped.
            if (addr_nx_q <= LIMIT) addr_d = addr_nx_q[NB_WIDHT:0];
            nwords_d = nwords_q - NB_BYTE'(1);
            if (nwords_q == NB_BYTE'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               rstpc_d = 1'b1;
               err_d   = ovf_q;
            end else begin
               state_d   = LOAD_DATA;
               take_byte = i_rx_valid;
            end
         end
         RUN: begin
            if (i_halt) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         STEP: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      addr_nx_d = {1'b0, addr_d} + STRIDE;
      if (take_byte) begin
         word_d = NB_REG'({word_q, i_rx_data});
         if (bcnt_q == CW'(BPW - 1)) begin
            bcnt_d  = '0;
            state_d = WRITE;
            if (addr_nx_d <= LIMIT) begin
               wmem_d = 1'b1;
               dout_d = word_d;
               aout_d = addr_d[NB_WIDHT-1:0];
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            bcnt_d = bcnt_q + CW'(1);
         end
      end
   end

   assign o_dunit_w_mem    = wmem_q;
   assign o_dunit_addr     = aout_q;
   assign o_dunit_data_if  = dout_q;
   assign o_dunit_clk_en   = (state_q == RUN) || (state_q == STEP);
   assign o_dunit_reset_pc = rstpc_q;
   assign o_busy           = (state_q != IDLE);
   assign o_done           = done_q;
   assign o_err            = err_q;
endmodule

// File: tb/tb_dunit_prog_loader.sv
// Bench for dunit_prog_loader: two instances (large and 16-byte memory) share one byte stream;
// a transaction-level model fills per-cycle expectations that a compare process checks.
module tb_dunit_prog_loader;
   localparam int MAXC = 2048;

   logic clk = 1'b0;
   logic rst, rx_valid, halt;
   logic [7:0] rx_data;
   int cyc = 0;
   int nchk = 0, nerr = 0;
   bit chk_on = 1'b0;

   logic wm_a, clken_a, rpc_a, busy_a, done_a, err_a;
   logic [8:0] addr_a;
   logic [31:0] data_a;
   logic wm_b, clken_b, rpc_b, busy_b, done_b, err_b;
   logic [3:0] addr_b;
   logic [31:0] data_b;

   dunit_prog_loader #(.NB_WIDHT(9)) u_a (
      .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
      .o_dunit_w_mem(wm_a), .o_dunit_addr(addr_a), .o_dunit_data_if(data_a),
      .o_dunit_clk_en(clken_a), .o_dunit_reset_pc(rpc_a), .o_busy(busy_a),
      .o_done(done_a), .o_err(err_a));

   dunit_prog_loader #(.NB_WIDHT(4)) u_b (
      .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
      .o_dunit_w_mem(wm_b), .o_dunit_addr(addr_b), .o_dunit_data_if(data_b),
      .o_dunit_clk_en(clken_b), .o_dunit_reset_pc(rpc_b), .o_busy(busy_b),
      .o_done(done_b), .o_err(err_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic o_wm[2], o_clk[2], o_rpc[2], o_busy[2], o_done[2], o_err[2];
   logic [8:0] o_addr[2];
   logic [31:0] o_data[2];
   assign o_wm[0] = wm_a;     assign o_wm[1] = wm_b;
   assign o_clk[0] = clken_a; assign o_clk[1] = clken_b;
   assign o_rpc[0] = rpc_a;   assign o_rpc[1] = rpc_b;
   assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
   assign o_done[0] = done_a; assign o_done[1] = done_b;
   assign o_err[0] = err_a;   assign o_err[1] = err_b;
   assign o_addr[0] = addr_a; assign o_addr[1] = {5'b0, addr_b};
   assign o_data[0] = data_a; assign o_data[1] = data_b;

   // Per-cycle expectations; index = edge number after which the output is visible.
   bit          e_w[2][MAXC];
   logic [8:0]  e_addr[2][MAXC];
   logic [31:0] e_data[2][MAXC];
   bit          e_err[2][MAXC];
   bit          e_done[MAXC], e_rpc[MAXC], e_clk[MAXC], e_busy[MAXC], e_clr[MAXC];
   logic [8:0]  m_addr[2];
   logic [31:0] m_data[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && cyc < MAXC) begin
         for (int d = 0; d < 2; d++) begin
            if (e_clr[cyc]) begin m_addr[d] = '0; m_data[d] = '0; end
            if (e_w[d][cyc]) begin m_addr[d] = e_addr[d][cyc]; m_data[d] = e_data[d][cyc]; end
            chk($sformatf("wmem%0d@%0d", d, cyc), 32'(o_wm[d]), 32'(e_w[d][cyc]));
            chk($sformatf("addr%0d@%0d", d, cyc), 32'(o_addr[d]), 32'(m_addr[d]));
            chk($sformatf("data%0d@%0d", d, cyc), o_data[d], m_data[d]);
            chk($sformatf("done%0d@%0d", d, cyc), 32'(o_done[d]), 32'(e_done[cyc]));
            chk($sformatf("rstpc%0d@%0d", d, cyc), 32'(o_rpc[d]), 32'(e_rpc[cyc]));
            chk($sformatf("err%0d@%0d", d, cyc), 32'(o_err[d]), 32'(e_err[d][cyc]));
            chk($sformatf("clken%0d@%0d", d, cyc), 32'(o_clk[d]), 32'(e_clk[cyc]));
            chk($sformatf("busy%0d@%0d", d, cyc), 32'(o_busy[d]), 32'(e_busy[cyc]));
         end
      end
   end

   // Observation log for the hand-computed literal checks.
   int wa_cyc[$];
   logic [8:0] wa_addr[$];
   logic [31:0] wa_data[$];
   int wb_n, rpc_cyc, errb_cyc, doneb_cyc, n_clk, n_done;
   logic [3:0] wb_last;

   always @(negedge clk) begin
      if (chk_on) begin
         if (wm_a) begin wa_cyc.push_back(cyc); wa_addr.push_back(addr_a); wa_data.push_back(data_a); end
         if (wm_b) begin wb_n++; wb_last = addr_b; end
         if (rpc_a) rpc_cyc = cyc;
         if (err_b) errb_cyc = cyc;
         if (done_b) doneb_cyc = cyc;
         if (clken_a) n_clk++;
         if (done_a) n_done++;
      end
   end

   task automatic clr_mon();
      wa_cyc.delete(); wa_addr.delete(); wa_data.delete();
      wb_n = 0; wb_last = '0; rpc_cyc = -1; errb_cyc = -1; doneb_cyc = -2; n_clk = 0; n_done = 0;
   endtask

   task automatic set_busy(input int from, input bit v);
      for (int c = from; c < MAXC; c++) e_busy[c] = v;
   endtask

   task automatic set_clk(input int from, input bit v);
      for (int c = from; c < MAXC; c++) e_clk[c] = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] b, output int e);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = b; e = cyc + 1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   logic [31:0] words[$];

   // Model of a load: word k lands at byte address 4k while it fits below the memory size.
   task automatic do_load(input int gap);
      int e, eL, n;
      int addr[2];
      bit ovf[2];
      int lim[2];
      lim[0] = 512; lim[1] = 16;
      n = words.size();
      send(8'h4C, eL);
      set_busy(eL, 1'b1);
      idle(gap); send(8'(n), e);
      if (n == 0) begin
         set_busy(e, 1'b0);
         e_done[e] = 1'b1;
      end else begin
         addr[0] = 0; addr[1] = 0; ovf[0] = 1'b0; ovf[1] = 1'b0;
         for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
               idle(gap);
               send(words[k][31-8*j -: 8], e);
            end
            for (int d = 0; d < 2; d++) begin
               if (addr[d] + 4 <= lim[d]) begin
                  e_w[d][e] = 1'b1; e_addr[d][e] = 9'(addr[d]); e_data[d][e] = words[k];
                  addr[d] += 4;
               end else ovf[d] = 1'b1;
            end
         end
         set_busy(e + 1, 1'b0);
         e_done[e+1] = 1'b1; e_rpc[e+1] = 1'b1;
         e_err[0][e+1] = ovf[0]; e_err[1][e+1] = ovf[1];
      end
      idle(2);
   endtask

   task automatic do_run(input int hdelay, input bit pre);
      int e, h;
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'h43; e = cyc + 1;
      if (pre) halt = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      h = pre ? e + 1 : e + hdelay;
      set_clk(e, 1'b1); set_busy(e, 1'b1);
      while (cyc < h) begin
         @(negedge clk);
         if (cyc + 1 == h) halt = 1'b1;
         if (cyc + 1 == e + 2 && e + 2 < h) begin rx_valid = 1'b1; rx_data = 8'h58; end
         @(posedge clk);
         #1 rx_valid = 1'b0;
      end
      set_clk(h, 1'b0); set_busy(h, 1'b0);
      e_done[h] = 1'b1;
      @(negedge clk) halt = 1'b0;
      idle(2);
   endtask

   task automatic do_step();
      int e;
      send(8'h53, e);
      e_clk[e] = 1'b1; e_busy[e] = 1'b1; e_done[e+1] = 1'b1;
      idle(2);
   endtask

   initial begin
      int e, eL, er;
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; halt = 1'b0;
      m_addr[0] = '0; m_addr[1] = '0; m_data[0] = '0; m_data[1] = '0;
      clr_mon();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wmem", 32'(wm_a), 0);   chk("rst_addr", 32'(addr_a), 0);
      chk("rst_data", data_a, 0);      chk("rst_clken", 32'(clken_a), 0);
      chk("rst_rstpc", 32'(rpc_a), 0); chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0); chk("rst_err", 32'(err_b), 0);
      rst = 1'b0; chk_on = 1'b1;
      idle(2);

      // Reset in the middle of a word, then a one-word load.
      send(8'h4C, eL); set_busy(eL, 1'b1);
      send(8'h03, e); send(8'hAA, e); send(8'hBB, e);
      @(negedge clk); rst = 1'b1; er = cyc + 1;
      e_clr[er] = 1'b1; set_busy(er, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      idle(1);
      clr_mon();
      words = '{32'h20000001};
      do_load(1);
      chk("t1_nwr", wa_cyc.size(), 1);
      if (wa_cyc.size() == 1) begin
         chk("t1_addr", 32'(wa_addr[0]), 0);
         chk("t1_data", wa_data[0], 32'h20000001);
         chk("t1_rstpc_lag", rpc_cyc, wa_cyc[0] + 1);
      end

      // Three-instruction program with gaps between bytes.
      clr_mon();
      words = '{32'h20010001, 32'hAC010004, 32'h8C020004};
      do_load(2);
      chk("t2_nwr", wa_cyc.size(), 3);
      chk("t2_ndone", n_done, 1);
      if (wa_cyc.size() == 3) begin
         chk("t2_a1", 32'(wa_addr[1]), 4);  chk("t2_a2", 32'(wa_addr[2]), 8);
         chk("t2_d0", wa_data[0], 32'h20010001);
         chk("t2_d1", wa_data[1], 32'hAC010004);
         chk("t2_d2", wa_data[2], 32'h8C020004);
      end

      // Back-to-back bytes, including during the write cycle.
      clr_mon();
      words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
      do_load(0);
      chk("t3_nwr", wa_cyc.size(), 4);
      if (wa_cyc.size() == 4) begin
         chk("t3_spacing", wa_cyc[1] - wa_cyc[0], 4);
         chk("t3_span", wa_cyc[3] - wa_cyc[0], 12);
         chk("t3_d3", wa_data[3], 32'hDDEEFF00);
      end

      // Empty load, PC reset command.
      words.delete();
      do_load(0);
      send(8'h52, e); e_done[e] = 1'b1; e_rpc[e] = 1'b1;
      idle(2);

      // Continuous run: halt sampled 7 edges after the command; stray byte ignored.
      clr_mon();
      do_run(7, 1'b0);
      chk("t6_clken_cycles", n_clk, 7);
      chk("t6_ndone", n_done, 1);
      clr_mon();
      do_run(1, 1'b1);
      chk("t7_clken_cycles", n_clk, 1);

      // Two single steps, then an unknown command.
      clr_mon();
      do_step(); do_step();
      chk("t8_clken_cycles", n_clk, 2);
      chk("t8_ndone", n_done, 2);
      send(8'h58, e); e_err[0][e] = 1'b1; e_err[1][e] = 1'b1;
      idle(2);

      // Five words: the 16-byte memory keeps four and flags the fifth.
      clr_mon();
      words = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D, 32'h0000000E};
      do_load(1);
      chk("t9_nwr_small", wb_n, 4);
      chk("t9_last_small", 32'(wb_last), 12);
      chk("t9_err_with_done", errb_cyc, doneb_cyc);
      chk("t9_nwr_big", wa_cyc.size(), 5);
      if (wa_cyc.size() == 5) chk("t9_a4_big", 32'(wa_addr[4]), 16);

      idle(4);
      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
